// File: rtl/rs_encode_stream_framer.sv
// Framing stage behind the RS encode stream wrapper: tags each data/parity line of a request with
// block_last/parity/last sideband and forwards it through a single registered val/rdy output stage.
module rs_encode_stream_framer #(
  parameter int NUM_REQ_BLOCKS   = 16,
  parameter int NUM_REQ_BLOCKS_W = $clog2(NUM_REQ_BLOCKS) + 1,
  parameter int DATA_W           = 512,
  parameter int RS_K             = 223,
  parameter int PARITY_BYTES     = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        src_framer_req_val,
  input  logic [NUM_REQ_BLOCKS_W-1:0] src_framer_req_num_blocks,
  output logic                        framer_src_req_rdy,
  input  logic                        src_framer_data_val,
  input  logic [DATA_W-1:0]           src_framer_data,
  output logic                        framer_src_data_rdy,
  output logic                        framer_dst_data_val,
  output logic [DATA_W-1:0]           framer_dst_data,
  output logic                        framer_dst_data_block_last,
  output logic                        framer_dst_data_parity,
  output logic                        framer_dst_data_last,
  input  logic                        dst_framer_data_rdy,
  output logic                        framer_busy
);

  localparam int DATA_BYTES   = DATA_W / 8;
  localparam int NUM_LINES    = (RS_K + DATA_BYTES - 1) / DATA_BYTES;
  localparam int PAR_PER_LINE = DATA_BYTES / PARITY_BYTES;
  localparam int PAR_SHIFT    = (PAR_PER_LINE > 1) ? $clog2(PAR_PER_LINE) : 0;
  localparam int LINE_CNT_W   = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;
  localparam int SUM_W        = NUM_REQ_BLOCKS_W + PAR_SHIFT + 1;
  localparam logic [LINE_CNT_W-1:0] LINE_LAST = LINE_CNT_W'(NUM_LINES - 1);

  if ((PAR_PER_LINE < 1) || ((1 << PAR_SHIFT) != PAR_PER_LINE)) begin : g_par_per_line_chk
    $error("PAR_PER_LINE must be a power of 2");
  end

  typedef enum logic [1:0] {IDLE, DATA, PARITY} state_t;

  state_t                      state_q, state_d;
  logic [NUM_REQ_BLOCKS_W-1:0] nb_q, nb_d;
  logic [NUM_REQ_BLOCKS_W-1:0] par_lines_q, par_lines_d;
  logic [LINE_CNT_W-1:0]       line_cnt_q, line_cnt_d;
  logic [NUM_REQ_BLOCKS_W-1:0] block_cnt_q, block_cnt_d;
  logic [NUM_REQ_BLOCKS_W-1:0] par_cnt_q, par_cnt_d;
  logic                        out_val_q, out_val_d;
  logic [DATA_W-1:0]           out_data_q, out_data_d;
  logic                        out_blast_q, out_blast_d;
  logic                        out_par_q, out_par_d;
  logic                        out_last_q, out_last_d;

  logic                        out_free;
  logic                        data_hs;
  logic                        line_blast, line_par, line_last;
  logic [SUM_W-1:0]            par_sum;
  logic [NUM_REQ_BLOCKS_W-1:0] par_lines_calc;

  // Output register accepts a new line whenever it is empty or being drained this cycle.
  assign out_free            = !out_val_q || dst_framer_data_rdy;
  assign framer_src_req_rdy  = (state_q == IDLE);
  assign framer_src_data_rdy = (state_q != IDLE) && out_free;
  assign data_hs             = src_framer_data_val && framer_src_data_rdy;
  assign par_sum             = SUM_W'(src_framer_req_num_blocks) + SUM_W'(PAR_PER_LINE - 1);
  assign par_lines_calc      = NUM_REQ_BLOCKS_W'(par_sum >> PAR_SHIFT);

  always_comb begin
    state_d     = state_q;
    nb_d        = nb_q;
    par_lines_d = par_lines_q;
    line_cnt_d  = line_cnt_q;
    block_cnt_d = block_cnt_q;
    par_cnt_d   = par_cnt_q;
    line_blast  = 1'b0;
    line_par    = 1'b0;
    line_last   = 1'b0;

    case (state_q)
      IDLE: begin
        // A zero-block request is consumed without producing any lines.
        if (src_framer_req_val && (src_framer_req_num_blocks != '0)) begin
          nb_d        = src_framer_req_num_blocks;
          par_lines_d = par_lines_calc;
          line_cnt_d  = '0;
          block_cnt_d = '0;
          par_cnt_d   = '0;
          state_d     = DATA;
        end
      end
      DATA: begin
        if (data_hs) begin
          line_blast = (line_cnt_q == LINE_LAST);
          if (line_blast) begin
            line_cnt_d  = '0;
            block_cnt_d = block_cnt_q + 1'b1;
            if (block_cnt_q == nb_q - 1'b1) begin
              state_d = PARITY;
            end
          end else begin
            line_cnt_d = line_cnt_q + 1'b1;
          end
        end
      end
      PARITY: begin
        if (data_hs) begin
          line_par  = 1'b1;
          line_last = (par_cnt_q == par_lines_q - 1'b1);
          par_cnt_d = par_cnt_q + 1'b1;
          if (line_last) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    out_val_d   = out_val_q;
    out_data_d  = out_data_q;
    out_blast_d = out_blast_q;
    out_par_d   = out_par_q;
    out_last_d  = out_last_q;
    if (out_free) begin
      out_val_d = data_hs;
      if (data_hs) begin
        out_data_d  = src_framer_data;
        out_blast_d = line_blast;
        out_par_d   = line_par;
        out_last_d  = line_last;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      nb_q        <= '0;
      par_lines_q <= '0;
      line_cnt_q  <= '0;
      block_cnt_q <= '0;
      par_cnt_q   <= '0;
      out_val_q   <= 1'b0;
      out_blast_q <= 1'b0;
      out_par_q   <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      nb_q        <= nb_d;
      par_lines_q <= par_lines_d;
      line_cnt_q  <= line_cnt_d;
      block_cnt_q <= block_cnt_d;
      par_cnt_q   <= par_cnt_d;
      out_val_q   <= out_val_d;
      out_blast_q <= out_blast_d;
      out_par_q   <= out_par_d;
      out_last_q  <= out_last_d;
    end
  end

  // Payload is qualified by out_val_q, so it needs no reset.
  always_ff @(posedge clk) begin
    out_data_q <= out_data_d;
  end

  assign framer_dst_data_val        = out_val_q;
  assign framer_dst_data            = out_data_q;
  assign framer_dst_data_block_last = out_blast_q;
  assign framer_dst_data_parity     = out_par_q;
  assign framer_dst_data_last       = out_last_q;
  assign framer_busy                = (state_q != IDLE) || out_val_q;

endmodule

// File: tb/tb_rs_encode_stream_framer.sv
// Scoreboard bench for rs_encode_stream_framer: expected lines are queued as the source hands them
// over and popped when the destination takes them.
module tb_rs_encode_stream_framer;

  localparam int NRB    = 16;
  localparam int NRB_W  = $clog2(NRB) + 1;
  localparam int DW     = 512;
  localparam int NLINES = 4;
  localparam int PPL    = 2;

  logic             clk;
  logic             rst;
  logic             src_framer_req_val;
  logic [NRB_W-1:0] src_framer_req_num_blocks;
  logic             framer_src_req_rdy;
  logic             src_framer_data_val;
  logic [DW-1:0]    src_framer_data;
  logic             framer_src_data_rdy;
  logic             framer_dst_data_val;
  logic [DW-1:0]    framer_dst_data;
  logic             framer_dst_data_block_last;
  logic             framer_dst_data_parity;
  logic             framer_dst_data_last;
  logic             dst_framer_data_rdy;
  logic             framer_busy;

  rs_encode_stream_framer #(
    .NUM_REQ_BLOCKS(NRB), .DATA_W(DW), .RS_K(223), .PARITY_BYTES(32)
  ) dut (
    .clk                       (clk),
    .rst                       (rst),
    .src_framer_req_val        (src_framer_req_val),
    .src_framer_req_num_blocks (src_framer_req_num_blocks),
    .framer_src_req_rdy        (framer_src_req_rdy),
    .src_framer_data_val       (src_framer_data_val),
    .src_framer_data           (src_framer_data),
    .framer_src_data_rdy       (framer_src_data_rdy),
    .framer_dst_data_val       (framer_dst_data_val),
    .framer_dst_data           (framer_dst_data),
    .framer_dst_data_block_last(framer_dst_data_block_last),
    .framer_dst_data_parity    (framer_dst_data_parity),
    .framer_dst_data_last      (framer_dst_data_last),
    .dst_framer_data_rdy       (dst_framer_data_rdy),
    .framer_busy               (framer_busy)
  );

  typedef struct {
    logic [DW-1:0] d;
    logic          bl;
    logic          par;
    logic          last;
  } exp_t;

  exp_t sb[$];
  int   errors;
  int   checks;
  int   out_cnt;
  int   rdy_mode;
  int   cyc;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  function automatic logic [DW-1:0] rnd_line();
    logic [DW-1:0] r;
    for (int k = 0; k < DW / 32; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic run_rdy();
    logic [3:0] pat;
    pat = 4'b1001;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      dst_framer_data_rdy = (rdy_mode == 0) ? 1'b1 : pat[cyc % 4];
    end
  endtask

  task automatic run_monitor();
    exp_t          e;
    logic          stall_pend;
    logic [DW-1:0] hold_d;
    logic [2:0]    hold_f;
    logic [2:0]    cur_f;
    stall_pend = 1'b0;
    forever begin
      @(negedge clk);
      cur_f = {framer_dst_data_block_last, framer_dst_data_parity, framer_dst_data_last};
      if (rst) begin
        stall_pend = 1'b0;
      end else begin
        if (src_framer_req_val && framer_src_req_rdy)
          assert (src_framer_req_num_blocks <= NRB)
            else $error("num_blocks %0d exceeds maximum", src_framer_req_num_blocks);
        if (stall_pend) begin
          checks++;
          if (!framer_dst_data_val || framer_dst_data !== hold_d || cur_f !== hold_f) begin
            errors++;
            $display("FAIL stall_hold: val=%0b flags=%b, required val=1 flags=%b and unchanged data",
                     framer_dst_data_val, cur_f, hold_f);
          end
        end
        stall_pend = framer_dst_data_val && !dst_framer_data_rdy;
        hold_d     = framer_dst_data;
        hold_f     = cur_f;
        if (framer_dst_data_val && dst_framer_data_rdy) begin
          out_cnt++;
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_line: got line %0d with empty scoreboard, required none", out_cnt);
          end else begin
            e = sb.pop_front();
            if (framer_dst_data !== e.d) begin
              errors++;
              $display("FAIL payload line %0d: got %h required %h", out_cnt, framer_dst_data[63:0], e.d[63:0]);
            end
            checks++;
            if (cur_f !== {e.bl, e.par, e.last}) begin
              errors++;
              $display("FAIL flags line %0d: got bl/par/last=%b required %b", out_cnt, cur_f, {e.bl, e.par, e.last});
            end
          end
        end
      end
    end
  endtask

  task automatic send_req(input int nb);
    bit got;
    got = 1'b0;
    src_framer_req_val        = 1'b1;
    src_framer_req_num_blocks = NRB_W'(nb);
    for (int t = 0; t < 200 && !got; t++) begin
      @(negedge clk);
      if (framer_src_req_rdy) got = 1'b1;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL req_timeout: req_rdy=0 after 200 cycles, required 1");
    end
    @(posedge clk);
    #1;
    src_framer_req_val = 1'b0;
  endtask

  task automatic send_lines(input int nb, input int max_lines);
    exp_t e;
    int   ndata, total, lim;
    bit   got;
    ndata = nb * NLINES;
    total = ndata + (nb + PPL - 1) / PPL;
    lim   = (max_lines < total) ? max_lines : total;
    for (int i = 0; i < lim; i++) begin
      e.d = rnd_line();
      if (i < ndata) begin
        e.bl = (i % NLINES) == NLINES - 1; e.par = 1'b0; e.last = 1'b0;
      end else begin
        e.bl = 1'b0; e.par = 1'b1; e.last = (i == total - 1);
      end
      src_framer_data_val = 1'b1;
      src_framer_data     = e.d;
      got = 1'b0;
      for (int t = 0; t < 200 && !got; t++) begin
        @(negedge clk);
        if (framer_src_data_rdy) begin
          sb.push_back(e);
          got = 1'b1;
        end
      end
      checks++;
      if (!got) begin
        errors++;
        $display("FAIL data_timeout line %0d: data_rdy=0 after 200 cycles, required 1", i);
      end
      @(posedge clk);
      #1;
    end
    src_framer_data_val = 1'b0;
  endtask

  task automatic drain_and_count(input string name, input int base, input int exp_lines);
    int t;
    t = 0;
    while ((sb.size() != 0 || framer_dst_data_val) && t < 600) begin
      @(negedge clk);
      t++;
    end
    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s drain: %0d lines outstanding, required 0", name, sb.size());
    end
    checks++;
    if (out_cnt - base !== exp_lines) begin
      errors++;
      $display("FAIL %s count: got %0d lines required %0d", name, out_cnt - base, exp_lines);
    end
    checks++;
    if (framer_dst_data_val !== 1'b0 || framer_busy !== 1'b0 || framer_src_req_rdy !== 1'b1) begin
      errors++;
      $display("FAIL %s idle: val=%0b busy=%0b req_rdy=%0b required 0/0/1", name,
               framer_dst_data_val, framer_busy, framer_src_req_rdy);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string name);
    @(negedge clk);
    checks++;
    if ({framer_dst_data_val, framer_src_req_rdy, framer_src_data_rdy, framer_busy} !== 4'b0100) begin
      errors++;
      $display("FAIL %s ctrl: val/req_rdy/data_rdy/busy=%b required 0100", name,
               {framer_dst_data_val, framer_src_req_rdy, framer_src_data_rdy, framer_busy});
    end
    checks++;
    if ({framer_dst_data_block_last, framer_dst_data_parity, framer_dst_data_last} !== 3'b000) begin
      errors++;
      $display("FAIL %s flags: got %b required 000", name,
               {framer_dst_data_block_last, framer_dst_data_parity, framer_dst_data_last});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset_state("reset");
  endtask

  task automatic test_single_block();
    int base;
    base = out_cnt;
    rdy_mode = 0;
    send_req(1);
    send_lines(1, 999);
    drain_and_count("nb1", base, 5);
  endtask

  task automatic test_three_blocks();
    int base;
    base = out_cnt;
    send_req(3);
    send_lines(3, 999);
    drain_and_count("nb3", base, 14);
  endtask

  task automatic test_stall();
    int base;
    base = out_cnt;
    rdy_mode = 1;
    send_req(5);
    send_lines(5, 999);
    drain_and_count("nb5_stall", base, 23);
    rdy_mode = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_zero_req();
    int base;
    base = out_cnt;
    send_req(0);
    @(negedge clk);
    checks++;
    if (framer_src_req_rdy !== 1'b1 || framer_busy !== 1'b0) begin
      errors++;
      $display("FAIL zero_req: req_rdy=%0b busy=%0b required 1/0", framer_src_req_rdy, framer_busy);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (out_cnt != base || framer_dst_data_val !== 1'b0) begin
      errors++;
      $display("FAIL zero_req_output: lines=%0d val=%0b required 0/0", out_cnt - base, framer_dst_data_val);
    end
    @(posedge clk);
    #1;
    send_req(1);
    send_lines(1, 999);
    drain_and_count("after_zero", base, 5);
  endtask

  task automatic test_mid_reset();
    int base;
    send_req(2);
    send_lines(2, 5);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    check_reset_state("mid_reset");
    base = out_cnt;
    send_req(1);
    send_lines(1, 999);
    drain_and_count("post_reset", base, 5);
  endtask

  task automatic test_back_to_back();
    int base;
    base = out_cnt;
    send_req(16);
    send_lines(16, 999);
    send_req(16);
    send_lines(16, 999);
    drain_and_count("nb16x2", base, 144);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    out_cnt = 0;
    rdy_mode = 0;
    cyc = 0;
    rst = 1'b1;
    src_framer_req_val = 1'b0;
    src_framer_req_num_blocks = '0;
    src_framer_data_val = 1'b0;
    src_framer_data = '0;
    dst_framer_data_rdy = 1'b1;
    fork
      run_rdy();
      run_monitor();
    join_none
    test_reset();
    test_single_block();
    test_three_blocks();
    test_stall();
    test_zero_req();
    test_mid_reset();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
